// File: rtl/cam_pattern_gen.sv
// Camera-style test pattern source: pclk, vsync/href timing and pixel bytes.
// Everything except pclk advances on the clk_50 edge where pclk falls.
module cam_pattern_gen #(
   parameter int H_ACTIVE      = 320,
   parameter int V_ACTIVE      = 240,
   parameter int BYTES_PER_PIX = 2,
   parameter int H_BLANK       = 144,
   parameter int VSYNC_LINES   = 3,
   parameter int VBACK_LINES   = 17,
   parameter int VFRONT_LINES  = 10
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] mode,
   input  logic [7:0] gray_level,
   output logic       pclk,
   output logic       vsync,
   output logic       href,
   output logic [7:0] data,
   output logic       frame_done
);

   localparam int ACT_BYTES = H_ACTIVE * BYTES_PER_PIX;
   localparam int LINE_LEN  = ACT_BYTES + H_BLANK;

   localparam logic [15:0] L_LAST  = 16'(LINE_LEN - 1);
   localparam logic [15:0] A_BYTES = 16'(ACT_BYTES);
   localparam logic [7:0]  B_LAST  = 8'(BYTES_PER_PIX - 1);
   localparam logic [15:0] VS_LAST = 16'(VSYNC_LINES - 1);
   localparam logic [15:0] VB_LAST = 16'(VBACK_LINES - 1);
   localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
   localparam logic [15:0] VF_LAST = 16'(VFRONT_LINES - 1);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBACK,
      ACTIVE,
      VFRONT
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] hcnt;
   logic [15:0] hcnt_nx;
   logic [15:0] xcnt;
   logic [15:0] xcnt_nx;
   logic [15:0] lcnt;
   logic [15:0] lcnt_nx;
   logic [7:0]  bcnt;
   logic [7:0]  bcnt_nx;
   logic [15:0] lines_last;
   logic [7:0]  frame_cnt;
   logic [7:0]  gray_q;
   logic [1:0]  mode_q;
   logic        upd;
   logic        line_end;
   logic        last_line;
   logic        done_nx;
   logic        href_nx;
   logic        frame_start;
   logic [7:0]  pix;
   logic [7:0]  data_nx;

   // pclk high now means this edge drives it low: the update edge
   assign upd       = pclk;
   assign line_end  = (hcnt == L_LAST);
   assign last_line = (lcnt == lines_last);

   always_comb begin
      lines_last = 16'd0;
      unique case (state)
         VSYNC:   lines_last = VS_LAST;
         VBACK:   lines_last = VB_LAST;
         ACTIVE:  lines_last = VA_LAST;
         VFRONT:  lines_last = VF_LAST;
         default: lines_last = 16'd0;
      endcase
   end

   always_comb begin
      state_nx = state;
      hcnt_nx  = hcnt;
      xcnt_nx  = xcnt;
      bcnt_nx  = bcnt;
      lcnt_nx  = lcnt;
      done_nx  = 1'b0;
      if (state == IDLE) begin
         if (enable) state_nx = VSYNC;
      end else if (line_end) begin
         hcnt_nx = 16'd0;
         xcnt_nx = 16'd0;
         bcnt_nx = 8'd0;
         if (last_line) begin
            lcnt_nx = 16'd0;
            unique case (state)
               VSYNC:  state_nx = VBACK;
               VBACK:  state_nx = ACTIVE;
               ACTIVE: state_nx = VFRONT;
               VFRONT: begin
                  done_nx  = 1'b1;
                  state_nx = enable ? VSYNC : IDLE;
               end
               default: state_nx = IDLE;
            endcase
         end else begin
            lcnt_nx = lcnt + 16'd1;
         end
      end else begin
         hcnt_nx = hcnt + 16'd1;
         if (bcnt == B_LAST) begin
            bcnt_nx = 8'd0;
            xcnt_nx = xcnt + 16'd1;
         end else begin
            bcnt_nx = bcnt + 8'd1;
         end
      end
   end

   always_comb begin
      pix = 8'h00;
      unique case (mode_q)
         2'd0: pix = gray_q;
         2'd1: pix = xcnt_nx[8:1];
         2'd2: pix = lcnt_nx[7:0];
         2'd3: pix = {8{xcnt_nx[4] ^ lcnt_nx[4]}};
      endcase
   end

   assign href_nx     = (state_nx == ACTIVE) && (hcnt_nx < A_BYTES);
   assign frame_start = (state_nx == VSYNC) && (state != VSYNC);

   always_comb begin
      data_nx = 8'h00;
      if (href_nx) data_nx = (bcnt_nx == 8'd0) ? pix : frame_cnt;
   end

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         pclk  <= 1'b0;
         state <= IDLE;
         hcnt  <= 16'd0;
         xcnt  <= 16'd0;
         bcnt  <= 8'd0;
         lcnt  <= 16'd0;
      end else begin
         pclk <= ~pclk;
         if (upd) begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
            xcnt  <= xcnt_nx;
            bcnt  <= bcnt_nx;
            lcnt  <= lcnt_nx;
         end
      end
   end

   // outputs are registered from next-state values so they align with state
   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         vsync      <= 1'b0;
         href       <= 1'b0;
         data       <= 8'h00;
         frame_done <= 1'b0;
         frame_cnt  <= 8'd0;
         mode_q     <= 2'd0;
         gray_q     <= 8'h00;
      end else begin
         frame_done <= 1'b0;
         if (upd) begin
            vsync      <= (state_nx == VSYNC);
            href       <= href_nx;
            data       <= data_nx;
            frame_done <= done_nx;
            if (done_nx) frame_cnt <= frame_cnt + 8'd1;
            if (frame_start) begin
               mode_q <= mode;
               gray_q <= gray_level;
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed bench for cam_pattern_gen using reduced frame geometry.
// A second tiny instance runs enough frames to wrap the frame counter.
module tb_cam_pattern_gen;

   localparam int HA  = 34;
   localparam int VA  = 34;
   localparam int BP  = 2;
   localparam int HB  = 4;
   localparam int VS  = 2;
   localparam int VB  = 2;
   localparam int VF  = 2;
   localparam int LL  = HA * BP + HB;
   localparam int FP  = (VS + VB + VA + VF) * LL;
   localparam int CHG = (VS + VB + 10) * LL + 5;

   logic       clk_50 = 1'b0;
   logic       rst_n = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] gray = 8'h00;
   logic       pclk;
   logic       vsync;
   logic       href;
   logic [7:0] data;
   logic       frame_done;

   logic       w_rst_n = 1'b1;
   logic       w_en = 1'b0;
   logic       w_pclk;
   logic       w_vsync;
   logic       w_href;
   logic [7:0] w_data;
   logic       w_done;

   int total = 0;
   int bad = 0;
   int timeouts = 0;
   int fd_cnt = 0;
   int fd_long = 0;
   logic fd_prev = 1'b0;
   int nz_blank = 0;

   logic s_vs = 0, s_hr = 0, p_vs = 0, p_hr = 0;
   logic [7:0] s_d = 0;
   int vs_len, first_hr, npulse, badlen;
   logic [7:0] fbuf [VA][HA*BP];

   int w_pos = 0;
   logic [7:0] w_q [$];

   typedef struct {
      string      nm;
      int         m;
      logic [7:0] g;
      logic [7:0] fc;
      logic [1:0] m2;
      logic [7:0] g2;
      logic       en2;
      bit         next;
   } fvec_t;

   always #10 clk_50 = ~clk_50;

   cam_pattern_gen #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .BYTES_PER_PIX(BP), .H_BLANK(HB),
      .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
   ) dut (
      .clk_50(clk_50), .reset(rst_n), .enable(enable), .mode(mode),
      .gray_level(gray), .pclk(pclk), .vsync(vsync), .href(href),
      .data(data), .frame_done(frame_done)
   );

   cam_pattern_gen #(
      .H_ACTIVE(2), .V_ACTIVE(1), .BYTES_PER_PIX(2), .H_BLANK(1),
      .VSYNC_LINES(1), .VBACK_LINES(1), .VFRONT_LINES(1)
   ) wdut (
      .clk_50(clk_50), .reset(w_rst_n), .enable(w_en), .mode(2'd0),
      .gray_level(8'h33), .pclk(w_pclk), .vsync(w_vsync), .href(w_href),
      .data(w_data), .frame_done(w_done)
   );

   always @(negedge clk_50) begin
      if (frame_done) fd_cnt++;
      if (frame_done && fd_prev) fd_long++;
      fd_prev = frame_done;
   end

   always @(negedge clk_50) begin
      if (w_pclk) begin
         if (w_href) begin
            if (w_pos % 2 == 1) w_q.push_back(w_data);
            w_pos++;
         end else begin
            w_pos = 0;
         end
      end
   end

   initial begin
      #(1800000);
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, want);
      end
   endtask

   task automatic step();
      int g = 0;
      @(negedge clk_50);
      while (!pclk && g < 4) begin
         @(negedge clk_50);
         g++;
      end
      if (!pclk) timeouts++;
      p_vs = s_vs;
      p_hr = s_hr;
      s_vs = vsync;
      s_hr = href;
      s_d  = data;
   endtask

   task automatic wait_vs(input string nm, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(s_vs && !p_vs) && n < budget);
      chk({nm, " vsync_rise"}, int'(s_vs && !p_vs), 1);
   endtask

   function automatic logic [7:0] exp_byte(input int m, input logic [7:0] g,
      input int x, input int y, input int b, input logic [7:0] fc);
      logic [15:0] xv;
      logic [15:0] yv;
      xv = 16'(x);
      yv = 16'(y);
      if (b != 0) return fc;
      case (m)
         0: return g;
         1: return xv[8:1];
         2: return yv[7:0];
         default: return (xv[4] ^ yv[4]) ? 8'hFF : 8'h00;
      endcase
   endfunction

   // loopback capture: one frame from the vsync rise into fbuf
   task automatic capture(input int chg, input logic [1:0] m2,
      input logic [7:0] g2, input logic en2);
      int line = -1;
      int col = 0;
      int hl = 0;
      vs_len = 0;
      first_hr = -1;
      npulse = 0;
      badlen = 0;
      for (int y = 0; y < VA; y++)
         for (int c = 0; c < HA*BP; c++) fbuf[y][c] = 'x;
      for (int i = 0; i < FP; i++) begin
         if (i > 0) step();
         if (i == chg) begin
            mode = m2;
            gray = g2;
            enable = en2;
         end
         if (s_vs) vs_len++;
         if (s_hr) begin
            if (!p_hr) begin
               if (first_hr < 0) first_hr = i;
               npulse++;
               line++;
               col = 0;
               hl = 0;
            end
            if (line >= 0 && line < VA && col < HA*BP) fbuf[line][col] = s_d;
            col++;
            hl++;
         end else begin
            if (p_hr && hl != HA*BP) badlen++;
            if (s_d != 8'h00) nz_blank++;
         end
      end
   endtask

   task automatic check_frame(input string nm, input int m, input logic [7:0] g,
      input logic [7:0] fc);
      int nb = 0;
      logic [7:0] e;
      chk({nm, " vsync_len"}, vs_len, VS*LL);
      chk({nm, " first_href"}, first_hr, (VS+VB)*LL);
      chk({nm, " href_pulses"}, npulse, VA);
      chk({nm, " href_len_errs"}, badlen, 0);
      for (int y = 0; y < VA; y++) begin
         for (int c = 0; c < HA*BP; c++) begin
            e = exp_byte(m, g, c / BP, y, c % BP, fc);
            if (fbuf[y][c] !== e) begin
               if (nb == 0)
                  $display("  %s first diff y=%0d byte=%0d got %h want %h",
                           nm, y, c, fbuf[y][c], e);
               nb++;
            end
         end
      end
      chk({nm, " data_errs"}, nb, 0);
   endtask

   initial begin
      fvec_t vec [4];
      int n;
      int fd0;
      logic a;
      logic b;

      vec[0] = '{"A", 1, 8'h00, 8'd0, 2'd3, 8'h00, 1'b1, 1'b1};
      vec[1] = '{"B", 3, 8'h00, 8'd1, 2'd0, 8'h5A, 1'b1, 1'b1};
      vec[2] = '{"C", 0, 8'h5A, 8'd2, 2'd2, 8'h5A, 1'b1, 1'b1};
      vec[3] = '{"D", 2, 8'h5A, 8'd3, 2'd2, 8'h5A, 1'b0, 1'b0};

      #5;
      rst_n = 1'b0;
      w_rst_n = 1'b0;
      repeat (3) @(negedge clk_50);
      chk("rst pclk", int'(pclk), 0);
      chk("rst vsync", int'(vsync), 0);
      chk("rst href", int'(href), 0);
      chk("rst data", int'(data), 0);
      chk("rst frame_done", int'(frame_done), 0);
      rst_n = 1'b1;
      @(negedge clk_50);
      chk("pclk resume", int'(pclk), 1);

      n = 0;
      repeat (5) begin
         step();
         if (s_vs || s_hr) n++;
      end
      chk("idle quiet", n, 0);

      mode = 2'd1;
      gray = 8'h00;
      enable = 1'b1;
      wait_vs("A", 10);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) fd0 = fd_cnt;
         capture(CHG, vec[k].m2, vec[k].g2, vec[k].en2);
         check_frame(vec[k].nm, vec[k].m, vec[k].g, vec[k].fc);
         if (k == 1) begin
            chk("B blk x16", int'(fbuf[0][32]), 8'hFF);
            chk("B blk y16", int'(fbuf[16][0]), 8'hFF);
            chk("B blk x16y16", int'(fbuf[16][32]), 8'h00);
         end
         if (vec[k].next) begin
            step();
            chk({vec[k].nm, " period"}, int'(s_vs && !p_vs), 1);
         end
      end

      n = 0;
      repeat (3*LL) begin
         step();
         if (s_vs || s_hr) n++;
      end
      chk("D idle quiet", n, 0);
      chk("D frame_done once", fd_cnt - fd0, 1);
      chk("frame_done total", fd_cnt, 4);
      @(negedge clk_50);
      a = pclk;
      @(negedge clk_50);
      b = pclk;
      chk("idle pclk toggle", int'(a != b), 1);

      mode = 2'd1;
      enable = 1'b1;
      wait_vs("E0", 10);
      repeat ((VS+VB+5)*LL + 10) step();
      chk("E href before rst", int'(s_hr), 1);
      rst_n = 1'b0;
      #1;
      chk("mid rst pclk", int'(pclk), 0);
      chk("mid rst vsync", int'(vsync), 0);
      chk("mid rst href", int'(href), 0);
      chk("mid rst data", int'(data), 0);
      chk("mid rst frame_done", int'(frame_done), 0);
      repeat (4) @(negedge clk_50);
      chk("rst hold pclk", int'(pclk), 0);
      rst_n = 1'b1;
      wait_vs("E", 10);
      capture(-1, 2'd1, 8'h00, 1'b1);
      check_frame("E", 1, 8'h00, 8'd0);
      enable = 1'b0;

      w_rst_n = 1'b1;
      w_en = 1'b1;
      n = 0;
      while (w_q.size() < 516 && n < 15000) begin
         @(negedge clk_50);
         n++;
      end
      chk("wrap bytes seen", int'(w_q.size() >= 516), 1);
      n = 0;
      for (int k = 0; k < 516 && k < w_q.size(); k++) begin
         if (w_q[k] !== 8'(k / 2)) n++;
      end
      chk("wrap seq errs", n, 0);
      if (w_q.size() >= 516) begin
         chk("wrap fc255", int'(w_q[510]), 255);
         chk("wrap fc0", int'(w_q[512]), 0);
      end

      chk("blank data nonzero", nz_blank, 0);
      chk("frame_done wide", fd_long, 0);
      chk("pclk timeouts", timeouts, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cam_pattern_gen.md
CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 Parameters SHALL be:
- H_ACTIVE: default 320; pixels per line.
- V_ACTIVE: default 240; active lines per frame.
- BYTES_PER_PIX: default 2; bytes per pixel on data.
- H_BLANK: default 144; pclk periods with href low after each line.
- VSYNC_LINES: default 3; lines with vsync high.
- VBACK_LINES: default 17; lines after vsync before the first active line.
- VFRONT_LINES: default 10; lines after the last active line.
REQ-002 clk_50  input  1  system clock; the block's only clock.
REQ-003 reset  input  1  asynchronous, active-low; already decided.
REQ-004 enable  input  1  frame generation enable; level-sensitive.
REQ-005 mode  input  2  pattern select; latched per frame.
REQ-006 gray_level  input  8  pixel value for mode 0; latched per frame.
REQ-007 pclk  output  1  pixel clock = clk_50/2; free-running out of reset.
REQ-008 vsync  output  1  frame sync, active high.
REQ-009 href  output  1  line valid, active high.
REQ-010 data  output  8  pixel byte stream.
REQ-011 frame_done  output  1  one clk_50-cycle pulse at the end of each frame.

Function
REQ-012 pclk SHALL be a register that toggles every clk_50 cycle.
REQ-013 vsync, href, data and all state SHALL update only on the clk_50 edge where pclk goes 1->0, so a receiver sampling on pclk rising edges sees stable values.
REQ-014 Line length L SHALL be H_ACTIVE*BYTES_PER_PIX + H_BLANK pclk periods (784 at default); href is high for the first H_ACTIVE*BYTES_PER_PIX periods.
REQ-015 The FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, VFRONT; each non-IDLE state lasts its parameter count of lines (V_ACTIVE lines for ACTIVE), each line being L pclk periods.
REQ-016 Transitions SHALL be:
- IDLE->VSYNC on enable=1.
- VSYNC->VBACK->ACTIVE->VFRONT as each state's line count completes.
- VFRONT->VSYNC if enable=1, else VFRONT->IDLE.
REQ-017 vsync SHALL be high exactly during VSYNC; href SHALL be low in every state except ACTIVE.
REQ-018 mode and gray_level SHALL be latched on entry to VSYNC and SHALL be held constant for the whole frame.
REQ-019 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes through VFRONT, then the FSM enters IDLE.
REQ-020 Within ACTIVE, pixel x = 0..H_ACTIVE-1, line y = 0..V_ACTIVE-1, byte index b = 0..BYTES_PER_PIX-1.
REQ-021 For b=0, data SHALL be pixel value p:
- mode 0: gray_level.
- mode 1: x[8:1].
- mode 2: y[7:0].
- mode 3: 8'hFF if x[4]^y[4], else 8'h00.
REQ-022 For b>=1, data SHALL be frame_cnt[7:0], an internal 8-bit counter that starts at 0 after reset, increments at each frame_done and wraps 255->0.
REQ-023 data SHALL be 8'h00 whenever href is low.
REQ-024 frame_done SHALL pulse high for one clk_50 cycle on the update edge that leaves VFRONT.
REQ-025 IDLE line/pixel counters SHALL be zero, so the first frame after enable starts at x=0, y=0.

Reset
REQ-026 While reset=0, outputs SHALL be pclk=0, vsync=0, href=0, data=0, frame_done=0, with state=IDLE, all counters 0 and frame_cnt=0.
REQ-027 Reset asserted mid-frame SHALL force the REQ-026 values immediately, with no completion of the frame.
REQ-028 After reset release, pclk SHALL resume toggling on the first clk_50 edge; enable is sampled from the first update edge.

Verification
REQ-029 Bench SHALL check: enable=1, defaults -> vsync high 3*784 pclk periods; the first href rise 20*784 periods after vsync rise; 240 href pulses of 640 periods each; frame period 270*784 pclk.
REQ-030 Bench SHALL check: mode=1 -> bytes in line y follow 0,fc,0,fc,1,fc,1,fc,...,159,fc,159,fc; mode=3 -> 8'hFF/8'h00 blocks toggle every 16 pixels and every 16 lines.
REQ-031 Bench SHALL check: mode changed from 0 to 2 mid-frame -> the current frame keeps mode 0, and the next frame shows y ramp 0..239.
REQ-032 Bench SHALL check: enable dropped during line 100 -> the frame completes, frame_done pulses once, then IDLE with vsync=href=0 and pclk still toggling.
REQ-033 Bench SHALL check: reset=0 mid-ACTIVE -> all outputs 0 in the same cycle; after release and enable, a new frame with frame_cnt=0.
REQ-034 Bench SHALL check: 257 frames -> byte1 sequence wraps 255->0; loopback into the camera-capture path fills a 320x240 buffer matching the expected pattern.
